// File: rtl/sher_vi_mem_responder.sv
// sher_vi_mem_responder
//
// Memory-side responder for the S.H.E.R. VI multi-cycle memory-memory
// datapath. A single-word read or write request is captured in IDLE. After
// LATENCY wait cycles the request is serviced from an internal word array.
// Completion is signalled by a one-cycle ACK, so the processor side can stall
// on real memory latency.
//
// Parameters:
//   DATA_W  - data word width in bits
//   ADDR_W  - word-address width
//   DEPTH   - number of implemented words (DEPTH <= 2**ADDR_W)
//   LATENCY - wait cycles between capture and access (0..15)
//
// Ports:
//   CLK    - single clock, all state updates on the rising edge
//   Reset  - synchronous, active-high reset
//   REQ    - request strobe, sampled only in IDLE
//   WE     - 1 = write, 0 = read, sampled with REQ
//   ADDR   - word address, sampled with REQ
//   WDATA  - write data, sampled with REQ
//   RDATA  - response data, valid with ACK, held until the next response
//   ACK    - one-cycle completion pulse
//   BUSY   - high from the capture cycle through RESP inclusive
//   ERR    - high with ACK when the captured address is >= DEPTH
module sher_vi_mem_responder #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              REQ,
    input  logic              WE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] WDATA,
    output logic [DATA_W-1:0] RDATA,
    output logic              ACK,
    output logic              BUSY,
    output logic              ERR
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_RESP
    } state_t;

    localparam logic [3:0] LAT4 = 4'(LATENCY);

    state_t            state;
    logic [3:0]        wait_cnt;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              in_range;

    logic [DATA_W-1:0] mem [DEPTH];

    // Unsigned compare of the latched address; folds to constant 1 when the
    // array fills the whole address space.
    assign in_range = (32'(lat_addr) < 32'(DEPTH));

    // Storage array. It is never cleared. A reset in the same cycle as the
    // ACCESS exit suppresses the write, so an aborted transaction leaves the
    // array untouched.
    always_ff @(posedge CLK) begin
        if (!Reset && (state == ST_ACCESS) && lat_we && in_range) begin
            mem[lat_addr] <= lat_wdata;
        end
    end

    // Control FSM with registered outputs. Only the latched request fields
    // are used after capture, so input changes outside IDLE are ignored.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            RDATA     <= '0;
            ACK       <= 1'b0;
            BUSY      <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ACK <= 1'b0;
                    ERR <= 1'b0;
                    if (REQ) begin
                        lat_we    <= WE;
                        lat_addr  <= ADDR;
                        lat_wdata <= WDATA;
                        BUSY      <= 1'b1;
                        wait_cnt  <= LAT4;
                        state     <= (LAT4 == 4'd0) ? ST_ACCESS : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Leave at a count of 1 without decrementing, so the
                    // counter never drops below 1 and can never wrap.
                    if (wait_cnt <= 4'd1) begin
                        state <= ST_ACCESS;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_ACCESS: begin
                    if (in_range) begin
                        RDATA <= lat_we ? lat_wdata : mem[lat_addr];
                        ERR   <= 1'b0;
                    end else begin
                        RDATA <= '0;
                        ERR   <= 1'b1;
                    end
                    ACK   <= 1'b1;
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    ACK   <= 1'b0;
                    ERR   <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sher_vi_mem_responder.sv
// tb_sher_vi_mem_responder
//
// Self-checking bench for sher_vi_mem_responder. Three instances are tested:
//   inst 0: DEPTH 1024, LATENCY 2
//   inst 1: DEPTH 1024, LATENCY 0
//   inst 2: DEPTH 1000, LATENCY 2
// Directed vectors come from a table. Hand-written sequences cover busy
// masking, back-to-back requests and reset aborts. Random traffic is checked
// against a word-array reference model.
module tb_sher_vi_mem_responder;

    typedef struct {
        int          dut;
        bit          we;
        int          addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset [3];
    logic        req   [3];
    logic        we    [3];
    logic [9:0]  addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic        ack   [3];
    logic        busy  [3];
    logic        err   [3];

    int errors = 0;
    int checks = 0;

    // Reference model: per-instance word array, written flags, last response.
    logic [31:0] model_mem   [3][1024];
    bit          model_valid [3][1024];
    logic [31:0] last_rdata  [3];

    always #5 clk = ~clk;

    sher_vi_mem_responder #(.DATA_W(32), .ADDR_W(10), .DEPTH(1024), .LATENCY(2)) dut0 (
        .CLK(clk), .Reset(reset[0]), .REQ(req[0]), .WE(we[0]), .ADDR(addr[0]),
        .WDATA(wdata[0]), .RDATA(rdata[0]), .ACK(ack[0]), .BUSY(busy[0]), .ERR(err[0])
    );

    sher_vi_mem_responder #(.DATA_W(32), .ADDR_W(10), .DEPTH(1024), .LATENCY(0)) dut1 (
        .CLK(clk), .Reset(reset[1]), .REQ(req[1]), .WE(we[1]), .ADDR(addr[1]),
        .WDATA(wdata[1]), .RDATA(rdata[1]), .ACK(ack[1]), .BUSY(busy[1]), .ERR(err[1])
    );

    sher_vi_mem_responder #(.DATA_W(32), .ADDR_W(10), .DEPTH(1000), .LATENCY(2)) dut2 (
        .CLK(clk), .Reset(reset[2]), .REQ(req[2]), .WE(we[2]), .ADDR(addr[2]),
        .WDATA(wdata[2]), .RDATA(rdata[2]), .ACK(ack[2]), .BUSY(busy[2]), .ERR(err[2])
    );

    function automatic int lat_of(input int d);
        return (d == 1) ? 0 : 2;
    endfunction

    function automatic int depth_of(input int d);
        return (d == 2) ? 1000 : 1024;
    endfunction

    // Expected response of a request according to the memory rules.
    function automatic void model_expect(input int d, input bit w, input int a,
                                         input logic [31:0] wd,
                                         output logic [31:0] rd, output bit e);
        if (a >= depth_of(d)) begin
            rd = 32'h0;
            e  = 1'b1;
        end else begin
            rd = w ? wd : model_mem[d][a];
            e  = 1'b0;
        end
    endfunction

    function automatic void model_commit(input int d, input bit w, input int a,
                                         input logic [31:0] wd);
        if (a < depth_of(d) && w) begin
            model_mem[d][a]   = wd;
            model_valid[d][a] = 1'b1;
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Issues one request and follows it through to the return to IDLE.
    // While the responder is busy, the inputs are scrambled. With noise_addr
    // >= 0, REQ is instead held high as a write to noise_addr, and this
    // request must be ignored.
    task automatic applyStimulus(input int d, input bit w, input int a,
                                 input logic [31:0] wd, input logic [31:0] exp_rd,
                                 input bit exp_e, input int noise_addr,
                                 input string name);
        int  k;
        int  extra;
        bit  got_ack;
        @(negedge clk);
        req[d]   = 1'b1;
        we[d]    = w;
        addr[d]  = 10'(a);
        wdata[d] = wd;
        @(posedge clk);
        @(negedge clk);
        k       = 0;
        got_ack = 1'b0;
        while (k < 40) begin
            if (noise_addr >= 0) begin
                req[d]   = 1'b1;
                we[d]    = 1'b1;
                addr[d]  = 10'(noise_addr);
                wdata[d] = $urandom;
            end else begin
                req[d]   = 1'b0;
                we[d]    = 1'($urandom);
                addr[d]  = 10'($urandom);
                wdata[d] = $urandom;
            end
            if (ack[d] === 1'b1) begin
                got_ack = 1'b1;
                break;
            end
            checkOutput({name, ".busy_wait"}, {31'b0, busy[d]}, 32'd1);
            checkOutput({name, ".rdata_hold"}, rdata[d], last_rdata[d]);
            @(negedge clk);
            k++;
        end
        req[d] = 1'b0;
        checkOutput({name, ".ack_cycle"}, 32'(k), 32'(lat_of(d) + 1));
        if (got_ack) begin
            checkOutput({name, ".rdata"}, rdata[d], exp_rd);
            checkOutput({name, ".err"}, {31'b0, err[d]}, {31'b0, exp_e});
            checkOutput({name, ".busy_resp"}, {31'b0, busy[d]}, 32'd1);
        end
        last_rdata[d] = exp_rd;
        @(negedge clk);
        checkOutput({name, ".ack_low"}, {31'b0, ack[d]}, 32'd0);
        checkOutput({name, ".busy_low"}, {31'b0, busy[d]}, 32'd0);
        checkOutput({name, ".err_low"}, {31'b0, err[d]}, 32'd0);
        checkOutput({name, ".rdata_idle"}, rdata[d], exp_rd);
        if (noise_addr >= 0) begin
            extra = 0;
            repeat (lat_of(d) + 3) begin
                @(negedge clk);
                if (ack[d] === 1'b1 || busy[d] === 1'b1) extra++;
            end
            checkOutput({name, ".no_second_txn"}, 32'(extra), 32'd0);
        end
    endtask

    // Captures a write, then asserts reset after cycles_in cycles of the
    // transaction. The transaction must be aborted with no ACK.
    task automatic abortWithReset(input int d, input int a, input logic [31:0] wd,
                                  input int cycles_in, input string name);
        int acks;
        @(negedge clk);
        req[d]   = 1'b1;
        we[d]    = 1'b1;
        addr[d]  = 10'(a);
        wdata[d] = wd;
        @(posedge clk);
        @(negedge clk);
        req[d] = 1'b0;
        repeat (cycles_in) @(negedge clk);
        reset[d] = 1'b1;
        @(negedge clk);
        reset[d] = 1'b0;
        checkOutput({name, ".busy"}, {31'b0, busy[d]}, 32'd0);
        checkOutput({name, ".rdata"}, rdata[d], 32'h0);
        acks = 0;
        repeat (6) begin
            if (ack[d] === 1'b1) acks++;
            @(negedge clk);
        end
        checkOutput({name, ".no_ack"}, 32'(acks), 32'd0);
        last_rdata[d] = 32'h0;
    endtask

    initial begin
        vec_t        vecs[$];
        logic [7:0]  ack_seen;
        logic [7:0]  busy_seen;
        logic [31:0] rd;
        bit          e;

        vecs.push_back('{0, 1'b1, 5,    32'hDEADBEEF, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{0, 1'b0, 5,    32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back('{0, 1'b1, 6,    32'h00000011, 32'h00000011, 1'b0});
        vecs.push_back('{0, 1'b0, 6,    32'h0,        32'h00000011, 1'b0});
        vecs.push_back('{0, 1'b1, 3,    32'h00003333, 32'h00003333, 1'b0});
        vecs.push_back('{0, 1'b1, 7,    32'h77777777, 32'h77777777, 1'b0});
        vecs.push_back('{0, 1'b1, 9,    32'h99999999, 32'h99999999, 1'b0});
        vecs.push_back('{1, 1'b1, 20,   32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0});
        vecs.push_back('{1, 1'b0, 20,   32'h0,        32'hA5A5A5A5, 1'b0});
        vecs.push_back('{2, 1'b1, 999,  32'h55AA55AA, 32'h55AA55AA, 1'b0});
        vecs.push_back('{2, 1'b1, 1000, 32'h12345678, 32'h00000000, 1'b1});
        vecs.push_back('{2, 1'b0, 999,  32'h0,        32'h55AA55AA, 1'b0});
        vecs.push_back('{2, 1'b0, 1023, 32'h0,        32'h00000000, 1'b1});

        for (int d = 0; d < 3; d++) begin
            reset[d] = 1'b1;
            req[d]   = 1'b0;
            we[d]    = 1'b0;
            addr[d]  = '0;
            wdata[d] = '0;
            last_rdata[d] = 32'h0;
            for (int a = 0; a < 1024; a++) model_valid[d][a] = 1'b0;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) reset[d] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("reset%0d.rdata", d), rdata[d], 32'h0);
            checkOutput($sformatf("reset%0d.ack", d), {31'b0, ack[d]}, 32'd0);
            checkOutput($sformatf("reset%0d.busy", d), {31'b0, busy[d]}, 32'd0);
            checkOutput($sformatf("reset%0d.err", d), {31'b0, err[d]}, 32'd0);
        end

        $display("[TB] directed table, %0d vectors", vecs.size());
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].dut, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                          vecs[i].exp_rdata, vecs[i].exp_err, -1,
                          $sformatf("vec%0d", i));
            model_commit(vecs[i].dut, vecs[i].we, vecs[i].addr, vecs[i].wdata);
        end

        $display("[TB] request while busy is ignored");
        applyStimulus(0, 1'b0, 3, 32'h0, 32'h00003333, 1'b0, 7, "busy_ignore");
        applyStimulus(0, 1'b0, 7, 32'h0, 32'h77777777, 1'b0, -1, "busy_ignore_rd7");

        $display("[TB] back-to-back requests at LATENCY 0");
        @(negedge clk);
        req[1]  = 1'b1;
        we[1]   = 1'b0;
        addr[1] = 10'd20;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            ack_seen[k]  = ack[1];
            busy_seen[k] = busy[1];
        end
        req[1] = 1'b0;
        checkOutput("b2b.ack_pattern", {24'b0, ack_seen}, 32'h00000092);
        checkOutput("b2b.busy_pattern", {24'b0, busy_seen}, 32'h000000DB);
        checkOutput("b2b.rdata", rdata[1], 32'hA5A5A5A5);
        @(negedge clk);
        checkOutput("b2b.idle", {31'b0, busy[1]}, 32'd0);
        last_rdata[1] = 32'hA5A5A5A5;

        $display("[TB] reset aborts in WAIT and ACCESS");
        abortWithReset(0, 9, 32'hCAFEF00D, 0, "abort_wait");
        applyStimulus(0, 1'b0, 9, 32'h0, 32'h99999999, 1'b0, -1, "abort_wait_rd9");
        abortWithReset(1, 20, 32'hCAFEF00D, 0, "abort_access");
        applyStimulus(1, 1'b0, 20, 32'h0, 32'hA5A5A5A5, 1'b0, -1, "abort_access_rd20");

        $display("[TB] random traffic against reference model");
        for (int it = 0; it < 90; it++) begin
            int          d;
            bit          w;
            int          a;
            logic [31:0] wd;
            int          noise;
            d  = it % 3;
            w  = 1'($urandom_range(0, 1));
            if (d == 2 && $urandom_range(0, 7) == 0) a = int'($urandom_range(1000, 1023));
            else a = int'($urandom_range(0, 1023));
            if (!w && a < depth_of(d) && !model_valid[d][a]) w = 1'b1;
            wd = $urandom;
            noise = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 999)) : -1;
            model_expect(d, w, a, wd, rd, e);
            applyStimulus(d, w, a, wd, rd, e, noise, $sformatf("rnd%0d", it));
            model_commit(d, w, a, wd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
